// File: rtl/mem_initiator_cache.sv
// Requester-side controller for the negative-edge main memory, with a direct-mapped,
// write-through, no-write-allocate word cache in front of it.
module mem_initiator_cache #(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 32,
  parameter int LINES  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_ack,
  output logic [DWIDTH-1:0] cpu_rdata,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [AWIDTH-1:0] addr_mem,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              ready_mem,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int IW = $clog2(LINES);
  localparam int TW = AWIDTH - IW;

  typedef enum logic [1:0] {IDLE, WAIT_MEM, MEM_RD, MEM_WR} state_t;

  state_t            state;
  logic [LINES-1:0]  valid;
  logic [TW-1:0]     tag_arr  [LINES];
  logic [DWIDTH-1:0] data_arr [LINES];

  logic              req_wr;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;

  logic [IW-1:0] cpu_idx, req_idx;
  logic [TW-1:0] cpu_tag, req_tag;
  logic          lookup_hit, store_hit;

  assign cpu_idx    = cpu_addr[IW-1:0];
  assign cpu_tag    = cpu_addr[AWIDTH-1:IW];
  assign req_idx    = req_addr[IW-1:0];
  assign req_tag    = req_addr[AWIDTH-1:IW];
  assign lookup_hit = valid[cpu_idx] && (tag_arr[cpu_idx] == cpu_tag);
  assign store_hit  = (state == IDLE) && cpu_wr && lookup_hit;
  assign cpu_busy   = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      valid      <= '0;
      rd_mem     <= 1'b0;
      wr_mem     <= 1'b0;
      cpu_ack    <= 1'b0;
      addr_mem   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      req_wr     <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
    end else begin
      rd_mem  <= 1'b0;
      wr_mem  <= 1'b0;
      cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          // Store wins when both requests are raised together.
          if (cpu_wr) begin
            req_wr    <= 1'b1;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            if (ready_mem) begin
              state     <= MEM_WR;
              wr_mem    <= 1'b1;
              addr_mem  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end else begin
              state <= WAIT_MEM;
            end
          end else if (cpu_rd) begin
            if (lookup_hit) begin
              cpu_rdata <= data_arr[cpu_idx];
              cpu_ack   <= 1'b1;
              if (hit_count != '1) hit_count <= hit_count + 16'd1;
            end else begin
              if (miss_count != '1) miss_count <= miss_count + 16'd1;
              req_wr   <= 1'b0;
              req_addr <= cpu_addr;
              if (ready_mem) begin
                state    <= MEM_RD;
                rd_mem   <= 1'b1;
                addr_mem <= cpu_addr;
              end else begin
                state <= WAIT_MEM;
              end
            end
          end
        end
        WAIT_MEM: begin
          if (ready_mem) begin
            addr_mem <= req_addr;
            if (req_wr) begin
              state     <= MEM_WR;
              wr_mem    <= 1'b1;
              mem_wdata <= req_wdata;
            end else begin
              state  <= MEM_RD;
              rd_mem <= 1'b1;
            end
          end
        end
        MEM_RD: begin
          cpu_rdata      <= mem_rdata;
          cpu_ack        <= 1'b1;
          valid[req_idx] <= 1'b1;
          state          <= IDLE;
        end
        MEM_WR: begin
          cpu_ack <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays need no reset: the valid bits qualify every lookup.
  always_ff @(posedge clk) begin
    if (state == MEM_RD) begin
      tag_arr[req_idx]  <= req_tag;
      data_arr[req_idx] <= mem_rdata;
    end else if (store_hit) begin
      data_arr[cpu_idx] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_mem_initiator_cache.sv
// Directed bench for mem_initiator_cache with a negative-edge word memory model.
module tb_mem_initiator_cache;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [8:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_busy, cpu_ack, rd_mem, wr_mem;
  logic [31:0] cpu_rdata, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [8:0]  addr_mem;
  logic        ready_mem = 1'b1;
  logic [15:0] hit_count, miss_count;
  logic [31:0] mem [512];

  int total = 0;
  int bad = 0;

  mem_initiator_cache #(.AWIDTH(9), .DWIDTH(32), .LINES(16)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .rd_mem(rd_mem), .wr_mem(wr_mem),
    .addr_mem(addr_mem), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .ready_mem(ready_mem), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Memory model: preload, then act on strobes at each falling edge.
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[9'h005] = 32'hDEADBEEF;
    mem[9'h015] = 32'hCAFEF00D;
    mem[9'h026] = 32'h0BADF00D;
    mem[9'h037] = 32'h11111111;
    forever begin
      @(negedge clk);
      if (rd_mem) mem_rdata <= mem[addr_mem];
      if (wr_mem) mem[addr_mem] = mem_wdata;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) tick();
    total++; if (cpu_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", cpu_busy); end
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL rst_ack: got %b want 0", cpu_ack); end
    total++; if (rd_mem !== 1'b0 || wr_mem !== 1'b0) begin bad++; $display("FAIL rst_strobes: got rd=%b wr=%b want 0 0", rd_mem, wr_mem); end
    total++; if (addr_mem !== 9'h0) begin bad++; $display("FAIL rst_addr: got %h want 000", addr_mem); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
    total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", cpu_rdata); end
    total++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin bad++; $display("FAIL rst_counters: got hit=%0d miss=%0d want 0 0", hit_count, miss_count); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_load_miss;
    cpu_rd = 1'b1; cpu_addr = 9'h005;
    tick();
    cpu_rd = 1'b0;
    total++; if (rd_mem !== 1'b1 || wr_mem !== 1'b0) begin bad++; $display("FAIL miss_strobe: got rd=%b wr=%b want 1 0", rd_mem, wr_mem); end
    total++; if (addr_mem !== 9'h005) begin bad++; $display("FAIL miss_addr: got %h want 005", addr_mem); end
    total++; if (cpu_busy !== 1'b1 || cpu_ack !== 1'b0) begin bad++; $display("FAIL miss_busy: got busy=%b ack=%b want 1 0", cpu_busy, cpu_ack); end
    tick();
    total++; if (rd_mem !== 1'b0) begin bad++; $display("FAIL miss_strobe_one_cycle: got %b want 0", rd_mem); end
    total++; if (cpu_ack !== 1'b1 || cpu_busy !== 1'b0) begin bad++; $display("FAIL miss_ack: got ack=%b busy=%b want 1 0", cpu_ack, cpu_busy); end
    total++; if (cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL miss_rdata: got %h want deadbeef", cpu_rdata); end
    total++; if (miss_count !== 16'd1 || hit_count !== 16'd0) begin bad++; $display("FAIL miss_count: got hit=%0d miss=%0d want 0 1", hit_count, miss_count); end
    tick();
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL miss_ack_pulse: got %b want 0", cpu_ack); end
  endtask

  task automatic test_load_hit;
    cpu_rd = 1'b1; cpu_addr = 9'h005;
    tick();
    cpu_rd = 1'b0;
    total++; if (cpu_ack !== 1'b1 || cpu_busy !== 1'b0) begin bad++; $display("FAIL hit_ack: got ack=%b busy=%b want 1 0", cpu_ack, cpu_busy); end
    total++; if (rd_mem !== 1'b0) begin bad++; $display("FAIL hit_no_strobe: got %b want 0", rd_mem); end
    total++; if (cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL hit_rdata: got %h want deadbeef", cpu_rdata); end
    total++; if (hit_count !== 16'd1 || miss_count !== 16'd1) begin bad++; $display("FAIL hit_count: got hit=%0d miss=%0d want 1 1", hit_count, miss_count); end
    tick();
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL hit_ack_pulse: got %b want 0", cpu_ack); end
  endtask

  task automatic test_store;
    cpu_wr = 1'b1; cpu_addr = 9'h005; cpu_wdata = 32'h12345678;
    tick();
    cpu_wr = 1'b0;
    total++; if (wr_mem !== 1'b1 || rd_mem !== 1'b0) begin bad++; $display("FAIL st_strobe: got wr=%b rd=%b want 1 0", wr_mem, rd_mem); end
    total++; if (addr_mem !== 9'h005 || mem_wdata !== 32'h12345678) begin bad++; $display("FAIL st_bus: got addr=%h data=%h want 005 12345678", addr_mem, mem_wdata); end
    tick();
    total++; if (wr_mem !== 1'b0 || cpu_ack !== 1'b1) begin bad++; $display("FAIL st_ack: got wr=%b ack=%b want 0 1", wr_mem, cpu_ack); end
    total++; if (mem[9'h005] !== 32'h12345678) begin bad++; $display("FAIL st_mem: got %h want 12345678", mem[9'h005]); end
    cpu_rd = 1'b1; cpu_addr = 9'h005;
    tick();
    cpu_rd = 1'b0;
    total++; if (cpu_ack !== 1'b1 || rd_mem !== 1'b0) begin bad++; $display("FAIL st_hit: got ack=%b rd=%b want 1 0", cpu_ack, rd_mem); end
    total++; if (cpu_rdata !== 32'h12345678) begin bad++; $display("FAIL st_hit_rdata: got %h want 12345678", cpu_rdata); end
    total++; if (hit_count !== 16'd2) begin bad++; $display("FAIL st_hit_count: got %0d want 2", hit_count); end
    tick();
  endtask

  task automatic test_back_to_back;
    cpu_rd = 1'b1; cpu_addr = 9'h005;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h12345678) begin bad++; $display("FAIL b2b_hit%0d: got ack=%b data=%h want 1 12345678", i, cpu_ack, cpu_rdata); end
    end
    cpu_rd = 1'b0;
    total++; if (hit_count !== 16'd5 || miss_count !== 16'd1) begin bad++; $display("FAIL b2b_count: got hit=%0d miss=%0d want 5 1", hit_count, miss_count); end
    tick();
  endtask

  task automatic test_conflict;
    cpu_rd = 1'b1; cpu_addr = 9'h015;
    tick();
    cpu_rd = 1'b0;
    total++; if (rd_mem !== 1'b1 || addr_mem !== 9'h015) begin bad++; $display("FAIL cf_miss1: got rd=%b addr=%h want 1 015", rd_mem, addr_mem); end
    tick();
    total++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL cf_data1: got ack=%b data=%h want 1 cafef00d", cpu_ack, cpu_rdata); end
    cpu_rd = 1'b1; cpu_addr = 9'h005;
    tick();
    cpu_rd = 1'b0;
    total++; if (rd_mem !== 1'b1 || addr_mem !== 9'h005) begin bad++; $display("FAIL cf_miss2: got rd=%b addr=%h want 1 005", rd_mem, addr_mem); end
    tick();
    total++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h12345678) begin bad++; $display("FAIL cf_data2: got ack=%b data=%h want 1 12345678", cpu_ack, cpu_rdata); end
    total++; if (miss_count !== 16'd3 || hit_count !== 16'd5) begin bad++; $display("FAIL cf_count: got hit=%0d miss=%0d want 5 3", hit_count, miss_count); end
    tick();
  endtask

  task automatic test_rd_wr_both;
    cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 9'h015; cpu_wdata = 32'hA5A5A5A5;
    tick();
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    total++; if (wr_mem !== 1'b1 || rd_mem !== 1'b0 || mem_wdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL both_store: got wr=%b rd=%b data=%h want 1 0 a5a5a5a5", wr_mem, rd_mem, mem_wdata); end
    tick();
    total++; if (cpu_ack !== 1'b1 || miss_count !== 16'd3 || hit_count !== 16'd5) begin bad++; $display("FAIL both_ack: got ack=%b hit=%0d miss=%0d want 1 5 3", cpu_ack, hit_count, miss_count); end
    cpu_rd = 1'b1; cpu_addr = 9'h015;
    tick();
    cpu_rd = 1'b0;
    total++; if (rd_mem !== 1'b1) begin bad++; $display("FAIL no_alloc_miss: got rd=%b want 1", rd_mem); end
    tick();
    total++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'hA5A5A5A5 || miss_count !== 16'd4) begin bad++; $display("FAIL no_alloc_data: got ack=%b data=%h miss=%0d want 1 a5a5a5a5 4", cpu_ack, cpu_rdata, miss_count); end
    tick();
  endtask

  task automatic test_wait_mem;
    ready_mem = 1'b0;
    cpu_rd = 1'b1; cpu_addr = 9'h026;
    tick();
    cpu_rd = 1'b0;
    total++; if (cpu_busy !== 1'b1 || rd_mem !== 1'b0 || miss_count !== 16'd5) begin bad++; $display("FAIL wait_enter: got busy=%b rd=%b miss=%0d want 1 0 5", cpu_busy, rd_mem, miss_count); end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (rd_mem !== 1'b0 || cpu_ack !== 1'b0 || cpu_busy !== 1'b1) begin bad++; $display("FAIL wait_hold%0d: got rd=%b ack=%b busy=%b want 0 0 1", i, rd_mem, cpu_ack, cpu_busy); end
    end
    ready_mem = 1'b1;
    tick();
    total++; if (rd_mem !== 1'b1 || addr_mem !== 9'h026 || cpu_ack !== 1'b0) begin bad++; $display("FAIL wait_strobe: got rd=%b addr=%h ack=%b want 1 026 0", rd_mem, addr_mem, cpu_ack); end
    tick();
    total++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h0BADF00D || cpu_busy !== 1'b0) begin bad++; $display("FAIL wait_ack: got ack=%b data=%h busy=%b want 1 0badf00d 0", cpu_ack, cpu_rdata, cpu_busy); end
    ready_mem = 1'b0;
    cpu_wr = 1'b1; cpu_addr = 9'h026; cpu_wdata = 32'h600DCAFE;
    tick();
    cpu_wr = 1'b0;
    total++; if (wr_mem !== 1'b0 || cpu_busy !== 1'b1) begin bad++; $display("FAIL wait_st_hold: got wr=%b busy=%b want 0 1", wr_mem, cpu_busy); end
    ready_mem = 1'b1;
    tick();
    total++; if (wr_mem !== 1'b1 || mem_wdata !== 32'h600DCAFE || addr_mem !== 9'h026) begin bad++; $display("FAIL wait_st_strobe: got wr=%b data=%h addr=%h want 1 600dcafe 026", wr_mem, mem_wdata, addr_mem); end
    tick();
    total++; if (cpu_ack !== 1'b1) begin bad++; $display("FAIL wait_st_ack: got %b want 1", cpu_ack); end
    cpu_rd = 1'b1; cpu_addr = 9'h026;
    tick();
    cpu_rd = 1'b0;
    total++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h600DCAFE || rd_mem !== 1'b0) begin bad++; $display("FAIL wait_st_hit: got ack=%b data=%h rd=%b want 1 600dcafe 0", cpu_ack, cpu_rdata, rd_mem); end
    tick();
  endtask

  task automatic test_reset_mid;
    cpu_rd = 1'b1; cpu_addr = 9'h037;
    tick();
    cpu_rd = 1'b0;
    total++; if (rd_mem !== 1'b1) begin bad++; $display("FAIL mid_strobe: got %b want 1", rd_mem); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (rd_mem !== 1'b0 || cpu_busy !== 1'b0 || addr_mem !== 9'h0) begin bad++; $display("FAIL mid_async: got rd=%b busy=%b addr=%h want 0 0 000", rd_mem, cpu_busy, addr_mem); end
    tick();
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL mid_no_ack: got %b want 0", cpu_ack); end
    reset_n = 1'b1;
    tick();
    total++; if (cpu_ack !== 1'b0 || rd_mem !== 1'b0) begin bad++; $display("FAIL mid_after: got ack=%b rd=%b want 0 0", cpu_ack, rd_mem); end
    cpu_rd = 1'b1; cpu_addr = 9'h005;
    tick();
    cpu_rd = 1'b0;
    total++; if (rd_mem !== 1'b1 || miss_count !== 16'd1 || hit_count !== 16'd0) begin bad++; $display("FAIL mid_invalid: got rd=%b hit=%0d miss=%0d want 1 0 1", rd_mem, hit_count, miss_count); end
    tick();
    total++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h12345678) begin bad++; $display("FAIL mid_refill: got ack=%b data=%h want 1 12345678", cpu_ack, cpu_rdata); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_miss();
    test_load_hit();
    test_store();
    test_back_to_back();
    test_conflict();
    test_rd_wr_both();
    test_wait_mem();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
